// File: rtl/l2_mem_sequencer.sv
// l2_mem_sequencer
//   Command sequencer between the L2 cache controller and SDRAM-style main
//   memory. Each accepted 64-bit L2 request becomes one closed-page
//   ACT -> READ/WRITE -> PRE sequence. The block owns the command bus and
//   slots in an auto-refresh every REF_INT cycles.
//
//   L2 handshake: the L2 raises req with we_in/addr_in/wdata and holds them
//   until ack. The request is captured on the edge at which the sequencer
//   leaves IDLE towards ACT. ack is a one-cycle pulse that ends the
//   transaction. A req still high during that pulse is not taken again.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req, we_in          L2 request and direction (1 = write)
//   addr_in, wdata      byte address and write data
//   ack, rdata          completion pulse, read data (held until next read)
//   busy                high whenever the FSM is not in IDLE
//   addr_out            memory address bus
//   CS, RAS, CAS, WE    registered, active-low memory command
//   mem_dq_out/oe/in    memory data bus, write drive and read input
//   state_dbg           current FSM state encoding
module l2_mem_sequencer #(
  parameter int T_RCD   = 2,
  parameter int CL      = 2,
  parameter int T_WR    = 2,
  parameter int T_RP    = 2,
  parameter int T_RFC   = 6,
  parameter int REF_INT = 780
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [63:0] wdata,
  output logic        ack,
  output logic [63:0] rdata,
  output logic        busy,
  output logic [19:0] addr_out,
  output logic        CS,
  output logic        RAS,
  output logic        CAS,
  output logic        WE,
  output logic [63:0] mem_dq_out,
  output logic        mem_dq_oe,
  input  logic [63:0] mem_dq_in,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD, S_RW, S_CASW, S_WREC, S_PRE, S_RPW, S_DONE, S_REF, S_RFCW
  } state_t;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam int RCW = $clog2(REF_INT);

  state_t         state, state_nxt;
  logic [7:0]     wait_cnt, wait_nxt;
  logic [RCW-1:0] ref_cnt;
  logic           ref_pending, ref_wrap, ref_due, accept;
  logic           we_q;
  logic [31:0]    addr_q;
  logic [63:0]    wdata_q;
  logic [3:0]     cmd_nxt;
  logic [19:0]    addr_nxt;
  logic           wr_beat_nxt;

  // A refresh that comes due on the same edge IDLE decides is taken at once.
  assign ref_wrap = (ref_cnt == RCW'(REF_INT - 1));
  assign ref_due  = ref_pending | ref_wrap;
  assign accept   = (state == S_IDLE) && !ref_due && req;

  // Wait states load (cycles - 1) on entry and leave when the count is 0.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (ref_due)  state_nxt = S_REF;
        else if (req) state_nxt = S_ACT;
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_nxt = S_RCD;
          wait_nxt  = 8'(T_RCD - 2);
        end else begin
          state_nxt = S_RW;
        end
      end
      S_RCD:  if (wait_cnt == 8'd0) state_nxt = S_RW;   else wait_nxt = wait_cnt - 8'd1;
      S_RW: begin
        if (!we_q) begin
          state_nxt = S_CASW;
          wait_nxt  = 8'(CL - 1);
        end else if (T_WR > 1) begin
          state_nxt = S_WREC;
          wait_nxt  = 8'(T_WR - 2);
        end else begin
          state_nxt = S_PRE;
        end
      end
      S_CASW: if (wait_cnt == 8'd0) state_nxt = S_PRE;  else wait_nxt = wait_cnt - 8'd1;
      S_WREC: if (wait_cnt == 8'd0) state_nxt = S_PRE;  else wait_nxt = wait_cnt - 8'd1;
      S_PRE: begin
        if (T_RP > 1) begin
          state_nxt = S_RPW;
          wait_nxt  = 8'(T_RP - 2);
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_RPW:  if (wait_cnt == 8'd0) state_nxt = S_DONE; else wait_nxt = wait_cnt - 8'd1;
      S_DONE: state_nxt = S_IDLE;
      S_REF: begin
        if (T_RFC > 1) begin
          state_nxt = S_RFCW;
          wait_nxt  = 8'(T_RFC - 2);
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RFCW: if (wait_cnt == 8'd0) state_nxt = S_IDLE; else wait_nxt = wait_cnt - 8'd1;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so the command
  // is on the bus during the cycle the FSM sits in the matching state.
  // ACT is only entered straight from IDLE, so it uses the live address.
  always_comb begin
    cmd_nxt     = CMD_NOP;
    addr_nxt    = '0;
    wr_beat_nxt = 1'b0;
    case (state_nxt)
      S_ACT: begin
        cmd_nxt  = CMD_ACT;
        addr_nxt = {addr_in[31:15], addr_in[14:12]};
      end
      S_RW: begin
        cmd_nxt     = we_q ? CMD_WRITE : CMD_READ;
        addr_nxt    = {8'b0, addr_q[11:3], addr_q[14:12]};
        wr_beat_nxt = we_q;
      end
      S_PRE:   begin cmd_nxt = CMD_PRE; addr_nxt = 20'h00400; end
      S_REF:   cmd_nxt = CMD_REF;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      wait_cnt            <= '0;
      ref_cnt             <= '0;
      ref_pending         <= 1'b0;
      we_q                <= 1'b0;
      addr_q              <= '0;
      wdata_q             <= '0;
      rdata               <= '0;
      ack                 <= 1'b0;
      addr_out            <= '0;
      {CS, RAS, CAS, WE}  <= CMD_DESEL;
      mem_dq_out          <= '0;
      mem_dq_oe           <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      ref_cnt     <= ref_wrap ? '0 : ref_cnt + RCW'(1);
      // Only one refresh is ever owed; it is discharged on entry to REF.
      ref_pending <= ref_due && (state_nxt != S_REF);
      if (accept) begin
        we_q    <= we_in;
        addr_q  <= addr_in;
        wdata_q <= wdata;
      end
      // Last CASW cycle is READ+CL: data is valid on mem_dq_in now.
      if (state == S_CASW && wait_cnt == 8'd0) rdata <= mem_dq_in;
      ack                <= (state_nxt == S_DONE);
      addr_out           <= addr_nxt;
      {CS, RAS, CAS, WE} <= cmd_nxt;
      mem_dq_oe          <= wr_beat_nxt;
      mem_dq_out         <= wr_beat_nxt ? wdata_q : '0;
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_l2_mem_sequencer.sv
// Bench for l2_mem_sequencer (REF_INT shortened to 16, other timings default).
// The reference model keeps one record per accepted operation (kind, accept
// cycle, latched request) and derives every cycle's expected bus from the
// timeline offsets. Cycle numbering restarts at 0 for the cycle that
// follows the last reset edge.
module tb_l2_mem_sequencer;

  localparam int T_RCD = 2, CL = 2, T_WR = 2, T_RP = 2, T_RFC = 6, REF_INT = 16;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_READ = 4'b0101,
                         C_WRITE = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_DESEL = 4'b1111;

  logic        clk, rst_n, req, we_in, ack, busy, CS, RAS, CAS, WE, mem_dq_oe;
  logic [31:0] addr_in;
  logic [63:0] wdata, rdata, mem_dq_out, mem_dq_in;
  logic [19:0] addr_out;
  logic [3:0]  state_dbg;
  logic        dq_fixed;

  l2_mem_sequencer #(.T_RCD(T_RCD), .CL(CL), .T_WR(T_WR), .T_RP(T_RP),
                     .T_RFC(T_RFC), .REF_INT(REF_INT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we_in(we_in), .addr_in(addr_in),
    .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy), .addr_out(addr_out),
    .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE), .mem_dq_out(mem_dq_out),
    .mem_dq_oe(mem_dq_oe), .mem_dq_in(mem_dq_in), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];   // expected read data, one entry per completed read

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // kind: 0 none, 1 read, 2 write, 3 refresh
  int          cyc = 0, kind = 0, start = 0, free_at = 0;
  bit          model_on = 0, in_rst_state = 0, ref_owed = 0;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, rdata_exp;

  function automatic logic [19:0] act_addr(input logic [31:0] a);
    logic [16:0] row;
    logic [2:0]  bank;
    row  = a[31:15];
    bank = a[14:12];
    return {row, bank};
  endfunction
  function automatic logic [19:0] rw_addr(input logic [31:0] a);
    logic [8:0] col;
    logic [2:0] bank;
    col  = a[11:3];
    bank = a[14:12];
    return {8'b0, col, bank};
  endfunction
  function automatic int rw_off();            return 1 + T_RCD; endfunction
  function automatic int pre_off(input int k); return (k == 1) ? rw_off() + CL + 1 : rw_off() + T_WR; endfunction
  function automatic int done_off(input int k); return pre_off(k) + T_RP; endfunction

  always @(posedge clk) begin
    int  n;
    bit  wrap;
    if (!rst_n) begin
      model_on = 1; in_rst_state = 1; cyc = 0; kind = 0; free_at = 0;
      ref_owed = 0; rdata_exp = '0;
    end else if (model_on) begin
      n    = cyc;
      wrap = (n % REF_INT) == REF_INT - 1;
      if (kind == 1 && n == start + rw_off() + CL) begin
        rdata_exp = mem_dq_in;
        exp_q.push_back(mem_dq_in);
      end
      if (n < free_at) begin
        ref_owed |= wrap;
      end else if (ref_owed || wrap) begin
        kind = 3; start = n; free_at = n + 1 + T_RFC; ref_owed = 0;
      end else if (req) begin
        kind = we_in ? 2 : 1; start = n; m_addr = addr_in; m_wdata = wdata;
        free_at = n + done_off(kind) + 1;
      end
      cyc = n + 1;
      in_rst_state = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [3:0]  e_cmd;
    logic [19:0] e_addr;
    logic        e_ack, e_busy, e_oe, addr_chk;
    int          d;
    if (model_on) begin
      e_cmd = in_rst_state ? C_DESEL : C_NOP;
      e_addr = '0; addr_chk = in_rst_state; e_ack = 0; e_busy = 0; e_oe = 0;
      if (!in_rst_state && kind != 0 && cyc > start && cyc < free_at) begin
        d = cyc - start;
        e_busy = 1;
        if (kind == 3) begin
          if (d == 1) e_cmd = C_REF;
        end else if (d == 1) begin
          e_cmd = C_ACT; e_addr = act_addr(m_addr); addr_chk = 1;
        end else if (d == rw_off()) begin
          e_cmd = (kind == 2) ? C_WRITE : C_READ; e_addr = rw_addr(m_addr);
          addr_chk = 1; e_oe = (kind == 2);
        end else if (d == pre_off(kind)) begin
          e_cmd = C_PRE; e_addr = 20'h00400; addr_chk = 1;
        end else if (d == done_off(kind)) begin
          e_ack = 1;
        end
      end
      chk("cmd", {CS, RAS, CAS, WE}, e_cmd);
      chk("ack", ack, e_ack);
      chk("busy", busy, e_busy);
      chk("dq_oe", mem_dq_oe, e_oe);
      chk("rdata", rdata, rdata_exp);
      if (addr_chk) chk("addr_out", addr_out, e_addr);
      if (e_oe) chk("dq_out", mem_dq_out, m_wdata);
      if (in_rst_state) chk("dq_out_rst", mem_dq_out, 64'h0);
      if (e_ack && kind == 1) begin
        if (exp_q.size() == 0) chk("rd_queue_empty", 64'd0, 64'd1);
        else chk("rd_queue", rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- memory data driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!dq_fixed) mem_dq_in = {$urandom, $urandom};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int k);
    rst_n = 1'b0;
    repeat (k) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Park at the negedge of model cycle c (bounded).
  task automatic wait_cyc(input int c);
    int guard = 0;
    @(negedge clk);
    while (cyc != c && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) chk("wait_cyc_timeout", 64'(cyc), 64'(c));
  endtask

  task automatic set_req(input logic w, input logic [31:0] a, input logic [63:0] d);
    req = 1'b1; we_in = w; addr_in = a; wdata = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req = 1'b0; we_in = 1'b0; addr_in = '0; wdata = '0;
    dq_fixed = 1'b1; mem_dq_in = '0;

    // Model pins against hand-derived values.
    chk("pin_act_5a48", act_addr(32'h0000_5A48), 20'h00005);
    chk("pin_rw_5a48", rw_addr(32'h0000_5A48), 20'h00A4D);
    chk("pin_act_fff", act_addr(32'hFFFF_F008), 20'hFFFFF);
    chk("pin_rw_fff", rw_addr(32'hFFFF_F008), 20'h0000F);
    chk("pin_pre_rd", 64'(pre_off(1)), 64'd6);
    chk("pin_done_rd", 64'(done_off(1)), 64'd8);
    chk("pin_pre_wr", 64'(pre_off(2)), 64'd5);
    chk("pin_done_wr", 64'(done_off(2)), 64'd7);

    // Reset held 3 cycles with req high, then a directed read.
    set_req(1'b0, 32'h0000_5A48, 64'h0);
    mem_dq_in = 64'hDEAD_BEEF_0123_4567;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", {CS, RAS, CAS, WE}, C_DESEL);
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_oe", mem_dq_oe, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(1); chk("rd_c1_cmd", {CS, RAS, CAS, WE}, C_ACT); chk("rd_c1_addr", addr_out, 20'h00005);
    wait_cyc(3); chk("rd_c3_cmd", {CS, RAS, CAS, WE}, C_READ); chk("rd_c3_addr", addr_out, 20'h00A4D);
    wait_cyc(6); chk("rd_c6_cmd", {CS, RAS, CAS, WE}, C_PRE);
    wait_cyc(8); chk("rd_c8_ack", ack, 1'b1); chk("rd_c8_data", rdata, 64'hDEAD_BEEF_0123_4567);
    @(posedge clk); #1 req = 1'b0;
    dq_fixed = 1'b0;

    // Directed write; inputs scrambled after accept must not matter.
    do_reset(2);
    set_req(1'b1, 32'hFFFF_F008, 64'hA5A5);
    wait_cyc(1); chk("wr_c1_cmd", {CS, RAS, CAS, WE}, C_ACT); chk("wr_c1_addr", addr_out, 20'hFFFFF);
    we_in = 1'b0; addr_in = 32'h1234_5678; wdata = 64'h0;
    wait_cyc(2); chk("wr_c2_oe", mem_dq_oe, 1'b0);
    wait_cyc(3); chk("wr_c3_cmd", {CS, RAS, CAS, WE}, C_WRITE); chk("wr_c3_addr", addr_out, 20'h0000F);
    chk("wr_c3_oe", mem_dq_oe, 1'b1); chk("wr_c3_dq", mem_dq_out, 64'hA5A5);
    wait_cyc(4); chk("wr_c4_oe", mem_dq_oe, 1'b0);
    wait_cyc(5); chk("wr_c5_cmd", {CS, RAS, CAS, WE}, C_PRE); chk("wr_c5_addr", addr_out, 20'h00400);
    wait_cyc(7); chk("wr_c7_ack", ack, 1'b1);
    @(posedge clk); #1 req = 1'b0;

    // Refresh on an idle bus; a req raised in the REF cycle waits for RFCW.
    do_reset(2);
    wait_cyc(16); chk("ref_c16", {CS, RAS, CAS, WE}, C_REF);
    set_req(1'b0, 32'h0001_2340, 64'h0);
    for (int c = 17; c <= 21; c++) begin
      wait_cyc(c); chk("rfcw_nop", {CS, RAS, CAS, WE}, C_NOP); chk("rfcw_busy", busy, 1'b1);
    end
    wait_cyc(22); chk("ref_idle_busy", busy, 1'b0);
    wait_cyc(23); chk("ref_then_act", {CS, RAS, CAS, WE}, C_ACT);
    wait_cyc(30); chk("ref_req_ack", ack, 1'b1);
    @(posedge clk); #1 req = 1'b0;

    // Collision: req and refresh due on the same IDLE edge.
    do_reset(2);
    dq_fixed = 1'b1; mem_dq_in = 64'h1122_3344_5566_7788;
    wait_cyc(15);
    set_req(1'b0, 32'h0000_5A48, 64'h0);
    wait_cyc(16); chk("col_ref", {CS, RAS, CAS, WE}, C_REF);
    wait_cyc(23); chk("col_act", {CS, RAS, CAS, WE}, C_ACT);
    wait_cyc(30); chk("col_ack", ack, 1'b1); chk("col_data", rdata, 64'h1122_3344_5566_7788);
    @(posedge clk); #1 req = 1'b0;
    dq_fixed = 1'b0;

    // Reset during CASW, then the held read runs again with default timing.
    do_reset(2);
    set_req(1'b0, 32'h0000_3008, 64'h0);
    wait_cyc(4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cmd", {CS, RAS, CAS, WE}, C_DESEL);
    chk("midrst_ack", ack, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(1); chk("midrst_act", {CS, RAS, CAS, WE}, C_ACT);
    wait_cyc(8); chk("midrst_ack2", ack, 1'b1);
    @(posedge clk); #1 req = 1'b0;

    // Randomized traffic with refreshes interleaved.
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      bit got;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 set_req(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
      got = 0;
      for (int k = 0; k < 80 && !got; k++) begin
        @(negedge clk);
        if (ack) got = 1;
        else if ($urandom_range(0, 1) == 1) begin
          we_in = 1'($urandom_range(0, 1)); addr_in = $urandom; wdata = {$urandom, $urandom};
        end
      end
      if (!got) chk("rand_ack_timeout", 64'd0, 64'd1);
      @(posedge clk); #1 req = 1'b0;
    end
    repeat (10) @(posedge clk);
    chk("rd_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
